// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    // Operand width used by the ALU divider.
    localparam int DIV_WIDTH = 8;

    // Iteration counter must hold the value DIV_WIDTH.
    localparam int CNT_W = $clog2(DIV_WIDTH + 1);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : divider_pkg

// File: rtl/divider_8bit_trial_subtractor.sv
// Combinational (WIDTH+1)-bit trial subtraction for one restoring-division step.
// A set o_negative means the shifted remainder is smaller than the divisor.
module trial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_rem_shift,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_diff,
    output logic             o_negative
);

    logic [WIDTH:0] w_diff;

    // Subtract the zero-extended divisor; the MSB of the result is the borrow.
    always_comb begin
        w_diff = i_rem_shift - {1'b0, i_divisor};
    end

    assign o_diff     = w_diff;
    assign o_negative = w_diff[WIDTH];

endmodule : trial_subtractor

// File: rtl/divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH
// clocks per divide, start/busy/done handshake, results held until the next
// operation completes. Divide by zero finishes immediately with a flag.
module divider_8bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t r_state;
    div_state_t w_state_next;

    // Partial remainder. The (WIDTH+1)-bit working value always has a zero
    // top bit between steps (R < D), so only the low WIDTH bits are stored.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_div;     // latched divisor
    logic [CW-1:0]    r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_negative;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Bring the next dividend bit into the remainder before the trial subtract.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};

    trial_subtractor #(
        .WIDTH(WIDTH)
    ) u_trial_subtractor (
        .i_rem_shift (w_rem_shift),
        .i_divisor   (r_div),
        .o_diff      (w_diff),
        .o_negative  (w_negative)
    );

    // Restore on a negative trial; otherwise keep the difference and emit a 1.
    always_comb begin
        w_rem_next = w_rem_shift[WIDTH-1:0];
        if (!w_negative) begin
            w_rem_next = w_diff[WIDTH-1:0];
        end
        w_quo_next = {r_quo[WIDTH-2:0], ~w_negative};
    end

    // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem         <= '0;
            r_quo         <= '0;
            r_div         <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_div <= divisor;
                            r_quo <= dividend;
                            r_rem <= '0;
                            r_cnt <= CW'(WIDTH);
                        end else begin
                            r_quotient    <= '1;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_quotient    <= w_quo_next;
                        r_remainder   <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule : divider_8bit

// File: tb/tb_divider_8bit.sv
// Self-checking bench for divider_8bit: directed cases, handshake timing,
// ignored starts, mid-operation reset and a random sweep against an
// arithmetic reference model.
module tb_divider_8bit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    // Last result the DUT should be holding.
    int held_q = 0;
    int held_r = 0;
    int held_z = 0;

    divider_8bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned division, all-ones quotient on divide by zero.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Launch one divide, follow it to done and check result, timing and hold.
    task automatic do_op(input int a, input int b, input string tag);
        int done_cyc = 0;
        int busy_bad = 0;
        int hold_bad = 0;
        int eq, er, ez;
        ref_div(a, b, eq, er, ez);
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) done_cyc = cyc;
            else if (int'(quotient) != held_q || int'(remainder) != held_r ||
                     int'(div_by_zero) != held_z) hold_bad++;
        end
        chk({tag, ".done_cycle"}, done_cyc, (b == 0) ? 1 : W + 1);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".div_by_zero"}, div_by_zero, ez);
        if (b != 0) begin
            chk({tag, ".invariant"}, int'(quotient) * b + int'(remainder), a);
            chk({tag, ".rem_lt_div"}, int'(int'(remainder) < b), 1);
        end
        chk({tag, ".busy_run"}, busy_bad, 0);
        chk({tag, ".hold_run"}, hold_bad, 0);
        @(negedge clk);
        chk({tag, ".busy_after"}, busy, 0);
        chk({tag, ".done_after"}, done, 0);
        held_q = eq;
        held_r = er;
        held_z = ez;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.div_by_zero", div_by_zero, 0);
        rst = 1'b0;

        // Directed operand cases.
        do_op(200, 7, "200/7");
        do_op(255, 1, "255/1");
        do_op(5, 9, "5/9");
        do_op(0, 3, "0/3");
        do_op(255, 255, "255/255");
        do_op(100, 0, "100/0");
        do_op(10, 3, "10/3");

        // Starts in cycles 3 and 9 are ignored; the one in cycle 10 is taken.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge clk);
            chk($sformatf("ignore.busy_c%0d", cyc), busy, (cyc == 10) ? 0 : 1);
            chk($sformatf("ignore.done_c%0d", cyc), done, (cyc == 9 || cyc == 19) ? 1 : 0);
            if (cyc == 9 || cyc == 10) begin
                chk($sformatf("ignore.q_c%0d", cyc), quotient, 28);
                chk($sformatf("ignore.r_c%0d", cyc), remainder, 4);
            end
            if (cyc == 19) begin
                chk("accept.q", quotient, 15);
                chk("accept.r", remainder, 0);
            end
            start    = (cyc == 3 || cyc == 9 || cyc == 10);
            dividend = (cyc == 10) ? 8'd60 : 8'd50;
            divisor  = (cyc == 10) ? 8'd4  : 8'd5;
        end
        start = 1'b0;
        @(negedge clk);

        // Reset in cycle 4 of 200/7 aborts the operation.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (cyc == 4);
            if (cyc >= 5) begin
                chk($sformatf("abort.busy_c%0d", cyc), busy, 0);
                chk($sformatf("abort.done_c%0d", cyc), done, 0);
            end
            if (cyc == 5) begin
                chk("abort.quotient", quotient, 0);
                chk("abort.remainder", remainder, 0);
                chk("abort.div_by_zero", div_by_zero, 0);
            end
        end
        held_q = 0;
        held_r = 0;
        held_z = 0;

        // Random sweep, with divisor forced to zero about one time in sixteen.
        for (int i = 0; i < 2000; i++) begin
            int a, b;
            a = $urandom_range(255, 0);
            b = ($urandom_range(15, 0) == 0) ? 0 : $urandom_range(255, 1);
            do_op(a, b, $sformatf("rnd%0d_%0d/%0d", i, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divider_8bit
